// File: rtl/mpram_write_scheduler_if.sv
// Requester and RAM write-port bundle for mpram_write_scheduler.
// The requester side drives clear and requests; the scheduler drives ready and the registered write ports.
interface mpram_write_scheduler_if #(
    parameter int DATA_DEPTH       = 128,
    parameter int DATA_WIDTH       = 64,
    parameter int BYTE_WRITE_WIDTH = 64,
    parameter int WPORTS_NUM       = 2,
    parameter int REQ_NUM          = 4
);
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
    localparam int BYTES_NUM  = DATA_WIDTH / BYTE_WRITE_WIDTH;

    // Handshake: a request transfers in the cycle where req_valid_i[k] and req_ready_o[k]
    // are both 1; valid must not depend on ready, and a request that is not ready is held.
    logic                                    clear_i;
    logic [REQ_NUM-1:0]                      req_valid_i;
    logic [REQ_NUM-1:0]                      req_ready_o;
    logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]      req_addr_i;
    logic [REQ_NUM-1:0][BYTES_NUM-1:0]       req_we_i;
    logic [REQ_NUM-1:0][DATA_WIDTH-1:0]      req_data_i;
    logic                                    init_busy_o;
    logic [WPORTS_NUM-1:0]                   en_w_o;
    logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]    we_o;
    logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0]   waddr_o;
    logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0]   data_o;

    modport master (
        output clear_i, req_valid_i, req_addr_i, req_we_i, req_data_i,
        input  req_ready_o, init_busy_o, en_w_o, we_o, waddr_o, data_o
    );

    modport slave (
        input  clear_i, req_valid_i, req_addr_i, req_we_i, req_data_i,
        output req_ready_o, init_busy_o, en_w_o, we_o, waddr_o, data_o
    );
endinterface

// File: rtl/mpram_write_scheduler.sv
// Write-port scheduler for the XOR multi-port RAM: zero-init sweep, then round-robin,
// address-conflict-free mapping of requesters onto write ports.
module mpram_write_scheduler #(
    parameter int DATA_DEPTH       = 128,
    parameter int DATA_WIDTH       = 64,
    parameter int BYTE_WRITE_WIDTH = 64,
    parameter int WPORTS_NUM       = 2,
    parameter int REQ_NUM          = 4
) (
    input logic                    clk,
    input logic                    rst,
    mpram_write_scheduler_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
    localparam int BYTES_NUM  = DATA_WIDTH / BYTE_WRITE_WIDTH;
    localparam int PTR_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int PORT_W     = (WPORTS_NUM > 1) ? $clog2(WPORTS_NUM) : 1;
    localparam int CNT_W      = $clog2(DATA_DEPTH + WPORTS_NUM + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                                state, state_nxt;
    logic [CNT_W-1:0]                      cnt, cnt_nxt;
    logic [PTR_W-1:0]                      ptr, ptr_nxt;
    logic [REQ_NUM-1:0]                    grant;
    logic [WPORTS_NUM-1:0]                 en_q, en_nxt;
    logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  we_q, we_nxt;
    logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] data_q, data_nxt;
    int                                    n_grant;
    int                                    idx;
    logic                                  conflict;
    logic [PTR_W-1:0]                      k;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        grant     = '0;
        en_nxt    = '0;
        we_nxt    = '0;
        addr_nxt  = '0;
        data_nxt  = '0;
        n_grant   = 0;
        idx       = 0;
        conflict  = 1'b0;
        k         = '0;
        if (bus.clear_i) begin
            state_nxt = INIT;
            cnt_nxt   = '0;
        end else if (state == INIT) begin
            for (int p = 0; p < WPORTS_NUM; p++) begin
                if (int'(cnt) + p < DATA_DEPTH) begin
                    en_nxt[p]   = 1'b1;
                    we_nxt[p]   = '1;
                    addr_nxt[p] = ADDR_WIDTH'(int'(cnt) + p);
                end
            end
            cnt_nxt = cnt + CNT_W'(WPORTS_NUM);
            if (int'(cnt) + WPORTS_NUM >= DATA_DEPTH) state_nxt = RUN;
        end else begin
            // Ports are filled in scan order; the address list built so far is addr_nxt[0..n_grant-1].
            for (int i = 0; i < REQ_NUM; i++) begin
                idx = int'(ptr) + i;
                if (idx >= REQ_NUM) idx = idx - REQ_NUM;
                k = PTR_W'(idx);
                conflict = 1'b0;
                for (int j = 0; j < WPORTS_NUM; j++) begin
                    if (j < n_grant && addr_nxt[j] == bus.req_addr_i[k]) conflict = 1'b1;
                end
                if (bus.req_valid_i[k] && n_grant < WPORTS_NUM && !conflict) begin
                    grant[k]                    = 1'b1;
                    en_nxt[PORT_W'(n_grant)]   = 1'b1;
                    we_nxt[PORT_W'(n_grant)]   = bus.req_we_i[k];
                    addr_nxt[PORT_W'(n_grant)] = bus.req_addr_i[k];
                    data_nxt[PORT_W'(n_grant)] = bus.req_data_i[k];
                    n_grant                     = n_grant + 1;
                    ptr_nxt = (idx == REQ_NUM - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            cnt    <= '0;
            ptr    <= '0;
            en_q   <= '0;
            we_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            en_q   <= en_nxt;
            we_q   <= we_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    // rst is folded in so ready is 0 and busy is 1 even before the state register has reset.
    assign bus.req_ready_o = grant & {REQ_NUM{~rst}};
    assign bus.init_busy_o = (state == INIT) | rst;
    assign bus.en_w_o      = en_q;
    assign bus.we_o        = we_q;
    assign bus.waddr_o     = addr_q;
    assign bus.data_o      = data_q;
endmodule

// File: tb/tb_mpram_write_scheduler.sv
// Directed bench for mpram_write_scheduler: an 8-word instance for sweep and arbitration,
// and a 7-word instance for the partial last sweep step and out-of-range forwarding.
module tb_mpram_write_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [1:0]       e_en;
    logic [1:0][1:0]  e_we;
    logic [1:0][2:0]  e_addr;
    logic [1:0][15:0] e_data;

    mpram_write_scheduler_if #(.DATA_DEPTH(8), .DATA_WIDTH(16), .BYTE_WRITE_WIDTH(8),
                               .WPORTS_NUM(2), .REQ_NUM(4)) bus8 ();
    mpram_write_scheduler_if #(.DATA_DEPTH(7), .DATA_WIDTH(16), .BYTE_WRITE_WIDTH(8),
                               .WPORTS_NUM(2), .REQ_NUM(4)) bus7 ();

    mpram_write_scheduler #(.DATA_DEPTH(8), .DATA_WIDTH(16), .BYTE_WRITE_WIDTH(8),
                            .WPORTS_NUM(2), .REQ_NUM(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    mpram_write_scheduler #(.DATA_DEPTH(7), .DATA_WIDTH(16), .BYTE_WRITE_WIDTH(8),
                            .WPORTS_NUM(2), .REQ_NUM(4)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [1:0] en, input logic [1:0][1:0] we,
                           input logic [2:0] a1, input logic [2:0] a0,
                           input logic [15:0] d1, input logic [15:0] d0);
        e_en      = en;
        e_we      = we;
        e_addr[1] = a1;
        e_addr[0] = a0;
        e_data[1] = d1;
        e_data[0] = d0;
    endtask

    task automatic idle_inputs();
        bus8.clear_i = 1'b0; bus8.req_valid_i = '0; bus8.req_we_i = '0; bus8.req_data_i = '0;
        bus7.clear_i = 1'b0; bus7.req_valid_i = '0; bus7.req_we_i = '0; bus7.req_data_i = '0;
        for (int i = 0; i < 4; i++) begin
            bus8.req_addr_i[i] = 3'(i);
            bus7.req_addr_i[i] = 3'(i);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus8.req_valid_i = 4'hF;
        step();
        step();
        set_exp(2'b00, '0, 3'd0, 3'd0, 16'h0, 16'h0);
        checks++;
        if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, bus8.req_ready_o, bus8.init_busy_o}
            !== {e_en, e_we, e_addr, e_data, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_during: got en=%b we=%h addr=%h data=%h ready=%b busy=%b, want zeros ready=0 busy=1",
                     bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, bus8.req_ready_o, bus8.init_busy_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, bus8.req_ready_o, bus8.init_busy_o}
            !== {e_en, e_we, e_addr, e_data, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_after: got en=%b we=%h addr=%h data=%h ready=%b busy=%b, want zeros ready=0 busy=1",
                     bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, bus8.req_ready_o, bus8.init_busy_o);
        end
        bus8.req_valid_i = '0;
    endtask

    // Starts in the first INIT cycle; leaves the bench in the first RUN cycle.
    task automatic test_sweep(input string tag, input bit with7);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if ({bus8.req_ready_o, bus8.init_busy_o} !== {4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL %s_init_ready step %0d: got ready=%b busy=%b, want ready=0000 busy=1",
                         tag, s, bus8.req_ready_o, bus8.init_busy_o);
            end
            step();
            set_exp(2'b11, '1, 3'(2 * s + 1), 3'(2 * s), 16'h0, 16'h0);
            checks++;
            if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o} !== {e_en, e_we, e_addr, e_data}) begin
                errors++;
                $display("FAIL %s_sweep8 step %0d: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                         tag, s, bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, e_en, e_we, e_addr, e_data);
            end
            if (with7) begin
                if (s == 3) set_exp(2'b01, 4'b0011, 3'd0, 3'd6, 16'h0, 16'h0);
                checks++;
                if ({bus7.en_w_o, bus7.we_o, bus7.waddr_o, bus7.data_o} !== {e_en, e_we, e_addr, e_data}) begin
                    errors++;
                    $display("FAIL %s_sweep7 step %0d: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                             tag, s, bus7.en_w_o, bus7.we_o, bus7.waddr_o, bus7.data_o, e_en, e_we, e_addr, e_data);
                end
            end
        end
        checks++;
        if (bus8.init_busy_o !== 1'b0 || (with7 && bus7.init_busy_o !== 1'b0)) begin
            errors++;
            $display("FAIL %s_busy_fall: got busy8=%b busy7=%b, want 0", tag, bus8.init_busy_o, bus7.init_busy_o);
        end
    endtask

    task automatic test_forward_we0();
        bus7.req_valid_i   = 4'b0001;
        bus7.req_addr_i[0] = 3'd7;
        bus7.req_we_i[0]   = 2'b00;
        bus7.req_data_i[0] = 16'h5A5A;
        #1;
        checks++;
        if (bus7.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL we0_ready: got %b want 0001", bus7.req_ready_o);
        end
        step();
        bus7.req_valid_i = '0;
        set_exp(2'b01, '0, 3'd0, 3'd7, 16'h0, 16'h5A5A);
        checks++;
        if ({bus7.en_w_o, bus7.we_o, bus7.waddr_o, bus7.data_o} !== {e_en, e_we, e_addr, e_data}) begin
            errors++;
            $display("FAIL we0_forward: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                     bus7.en_w_o, bus7.we_o, bus7.waddr_o, bus7.data_o, e_en, e_we, e_addr, e_data);
        end
    endtask

    task automatic test_distinct();
        bus8.req_valid_i = 4'b0111;
        for (int i = 0; i < 3; i++) bus8.req_addr_i[i] = 3'(i);
        bus8.req_we_i[0] = 2'b11; bus8.req_we_i[1] = 2'b01; bus8.req_we_i[2] = 2'b10;
        bus8.req_data_i[0] = 16'h1111; bus8.req_data_i[1] = 16'h2222; bus8.req_data_i[2] = 16'h3333;
        #1;
        checks++;
        if (bus8.req_ready_o !== 4'b0011) begin
            errors++;
            $display("FAIL distinct_ready0: got %b want 0011", bus8.req_ready_o);
        end
        step();
        bus8.req_valid_i = 4'b0100;
        set_exp(2'b11, {2'b01, 2'b11}, 3'd1, 3'd0, 16'h2222, 16'h1111);
        checks++;
        if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o} !== {e_en, e_we, e_addr, e_data}) begin
            errors++;
            $display("FAIL distinct_ports0: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                     bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, e_en, e_we, e_addr, e_data);
        end
        #1;
        checks++;
        if (bus8.req_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL distinct_ready1: got %b want 0100", bus8.req_ready_o);
        end
        step();
        bus8.req_valid_i = '0;
        set_exp(2'b01, {2'b00, 2'b10}, 3'd0, 3'd2, 16'h0, 16'h3333);
        checks++;
        if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o} !== {e_en, e_we, e_addr, e_data}) begin
            errors++;
            $display("FAIL distinct_ports1: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                     bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, e_en, e_we, e_addr, e_data);
        end
    endtask

    // Entered with ptr=3: requester 0 wins the scan, requester 1 collides on the same address.
    task automatic test_conflict();
        bus8.req_valid_i   = 4'b0011;
        bus8.req_addr_i[0] = 3'd5; bus8.req_addr_i[1] = 3'd5;
        bus8.req_we_i[0]   = 2'b11; bus8.req_we_i[1] = 2'b11;
        bus8.req_data_i[0] = 16'hAAAA; bus8.req_data_i[1] = 16'hBBBB;
        #1;
        checks++;
        if (bus8.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL conflict_ready0: got %b want 0001", bus8.req_ready_o);
        end
        step();
        bus8.req_valid_i = 4'b0010;
        set_exp(2'b01, {2'b00, 2'b11}, 3'd0, 3'd5, 16'h0, 16'hAAAA);
        checks++;
        if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o} !== {e_en, e_we, e_addr, e_data}) begin
            errors++;
            $display("FAIL conflict_ports0: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                     bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, e_en, e_we, e_addr, e_data);
        end
        #1;
        checks++;
        if (bus8.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL conflict_ready1: got %b want 0010", bus8.req_ready_o);
        end
        step();
        bus8.req_valid_i = '0;
        set_exp(2'b01, {2'b00, 2'b11}, 3'd0, 3'd5, 16'h0, 16'hBBBB);
        checks++;
        if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o} !== {e_en, e_we, e_addr, e_data}) begin
            errors++;
            $display("FAIL conflict_ports1: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                     bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, e_en, e_we, e_addr, e_data);
        end
    endtask

    // Entered with ptr=2, so the alternation starts with requesters 2,3.
    task automatic test_fairness();
        for (int i = 0; i < 4; i++) begin
            bus8.req_addr_i[i] = 3'(i);
            bus8.req_we_i[i]   = 2'b11;
            bus8.req_data_i[i] = 16'hC000 + 16'(i);
        end
        bus8.req_valid_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (bus8.req_ready_o !== ((c % 2 == 0) ? 4'b1100 : 4'b0011)) begin
                errors++;
                $display("FAIL fair_ready cycle %0d: got %b want %b", c, bus8.req_ready_o,
                         (c % 2 == 0) ? 4'b1100 : 4'b0011);
            end
            step();
            if (c % 2 == 0) set_exp(2'b11, '1, 3'd3, 3'd2, 16'hC003, 16'hC002);
            else            set_exp(2'b11, '1, 3'd1, 3'd0, 16'hC001, 16'hC000);
            checks++;
            if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o} !== {e_en, e_we, e_addr, e_data}) begin
                errors++;
                $display("FAIL fair_ports cycle %0d: got en=%b we=%h addr=%h data=%h, want en=%b we=%h addr=%h data=%h",
                         c, bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, e_en, e_we, e_addr, e_data);
            end
        end
    endtask

    // Entered with ptr=2 and all requesters still valid; leaves ptr=1.
    task automatic test_clear();
        bus8.clear_i = 1'b1;
        #1;
        checks++;
        if (bus8.req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL clear_ready: got %b want 0000", bus8.req_ready_o);
        end
        step();
        bus8.clear_i = 1'b0;
        checks++;
        if ({bus8.en_w_o, bus8.init_busy_o} !== {2'b00, 1'b1}) begin
            errors++;
            $display("FAIL clear_enter: got en=%b busy=%b want en=00 busy=1", bus8.en_w_o, bus8.init_busy_o);
        end
        test_sweep("clear", 1'b0);
        #1;
        checks++;
        if (bus8.req_ready_o !== 4'b1100) begin
            errors++;
            $display("FAIL clear_resume_ready: got %b want 1100", bus8.req_ready_o);
        end
        step();
        bus8.req_valid_i = 4'b0001;
        checks++;
        if ({bus8.en_w_o, bus8.waddr_o} !== {2'b11, 3'd3, 3'd2}) begin
            errors++;
            $display("FAIL clear_resume_ports: got en=%b addr=%h want en=11 addr=1a", bus8.en_w_o, bus8.waddr_o);
        end
        step();
        bus8.req_valid_i = '0;
    endtask

    task automatic test_reset_mid_init();
        bus8.clear_i = 1'b1;
        step();
        bus8.clear_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        set_exp(2'b00, '0, 3'd0, 3'd0, 16'h0, 16'h0);
        checks++;
        if ({bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, bus8.init_busy_o}
            !== {e_en, e_we, e_addr, e_data, 1'b1}) begin
            errors++;
            $display("FAIL midinit_reset: got en=%b we=%h addr=%h data=%h busy=%b, want zeros busy=1",
                     bus8.en_w_o, bus8.we_o, bus8.waddr_o, bus8.data_o, bus8.init_busy_o);
        end
        bus8.req_valid_i = 4'hF;
        test_sweep("midinit", 1'b1);
        #1;
        checks++;
        if (bus8.req_ready_o !== 4'b0011) begin
            errors++;
            $display("FAIL midinit_ptr_reset: got %b want 0011", bus8.req_ready_o);
        end
        step();
        bus8.req_valid_i = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_sweep("init", 1'b1);
        step();
        checks++;
        if (bus8.en_w_o !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_sweep: got en=%b want 00", bus8.en_w_o);
        end
        test_forward_we0();
        test_distinct();
        test_conflict();
        test_fairness();
        test_clear();
        test_reset_mid_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mpram_write_scheduler.md
# mpram_write_scheduler

Requester-side front end for the XOR-based multi-port RAM. It arbitrates REQ_NUM independent write requesters onto the RAM's WPORTS_NUM write ports and guarantees that no two ports write the same address in the same cycle, a case the XOR banks cannot resolve. After reset, or on request, it runs a sweep that writes zero to every address through all ports, so the XOR bank contents start out mutually consistent. Its outputs connect directly to the RAM's en_w_i / we_i / waddr_i / data_i inputs in common_clock mode.

## Interface
- DATA_DEPTH, 128: RAM words. ADDR_WIDTH = $clog2(DATA_DEPTH).
- DATA_WIDTH, 64: word width.
- BYTE_WRITE_WIDTH, 64: byte-enable granule. BYTES_NUM = DATA_WIDTH / BYTE_WRITE_WIDTH.
- WPORTS_NUM, 2: RAM write ports. Must be ≥1.
- REQ_NUM, 4: requester channels. Must be ≥WPORTS_NUM.

Ports:
- clk  in  1  single clock; drives all RAM write ports.
- rst  in  1  synchronous, active-high reset.
- clear_i  in  1  one-cycle pulse that restarts the zero-init sweep.
- req_valid_i  in  [REQ_NUM]  request valid.
- req_ready_o  out  [REQ_NUM]  request accepted this cycle. Combinational.
- req_addr_i  in  [REQ_NUM][ADDR_WIDTH]  write address.
- req_we_i  in  [REQ_NUM][BYTES_NUM]  byte enables.
- req_data_i  in  [REQ_NUM][DATA_WIDTH]  write data.
- init_busy_o  out  1  high while in INIT.
- en_w_o  out  [WPORTS_NUM]  port enable. Registered.
- we_o  out  [WPORTS_NUM][BYTES_NUM]  byte enables. Registered.
- waddr_o  out  [WPORTS_NUM][ADDR_WIDTH]  address. Registered.
- data_o  out  [WPORTS_NUM][DATA_WIDTH]  data. Registered.

## Operation
- FSM states: INIT and RUN.
  - rst forces INIT with cnt=0.
  - clear_i in RUN moves to INIT with cnt=0.
  - clear_i in INIT restarts with cnt=0.
- INIT behaviour, for each port p:
  - If cnt+p < DATA_DEPTH: en_w=1, we=all ones, waddr=cnt+p, data=0. Otherwise en_w=0.
  - cnt += WPORTS_NUM each cycle.
  - The cycle whose writes reach DATA_DEPTH-1 is the last INIT cycle; the next state is RUN.
  - The sweep takes ceil(DATA_DEPTH/WPORTS_NUM) cycles.
  - All req_ready_o are 0 throughout INIT.
- RUN arbitration:
  - Round-robin pointer ptr ∈ [0, REQ_NUM).
  - Scan requesters ptr, ptr+1, … (mod REQ_NUM).
  - Requester k is granted if req_valid_i[k]=1, fewer than WPORTS_NUM grants exist so far, and req_addr_i[k] differs from every address already granted this cycle.
  - A skipped requester is simply not ready; it keeps its request.
  - The j-th grant in scan order drives port j next cycle.
- req_ready_o[k] = grant[k]. Requesters must not derive valid from ready.
- ptr update: ptr ← (index of last granted requester + 1) mod REQ_NUM. With no grant, ptr is unchanged.
- Unused ports: en_w_o=0 and we_o/waddr_o/data_o=0.
- Requests with req_we_i=0 are still accepted and forwarded with en_w=1, we=0.
- Addresses ≥ DATA_DEPTH are forwarded unchanged. The requester is responsible for range.
- clear_i in RUN takes effect immediately: no grants in that cycle, and the next cycle begins the sweep.

## Timing
- During rst and the cycle after: en_w_o=0, we_o=0, waddr_o=0, data_o=0, req_ready_o=0, init_busy_o=1, ptr=0.
- init_busy_o is decoded from state:
  - It is 1 from reset through the last INIT cycle.
  - First RUN cycle = reset release + ceil(DATA_DEPTH/WPORTS_NUM).
- Write outputs lag their cause by one cycle:
  - accept (valid&ready) in cycle t → en_w_o/we/addr/data at t+1;
  - an INIT step at t → en_w_o at t+1.
- The output register after the last INIT step still carries sweep writes while the FSM is in RUN. Grants in the first RUN cycle appear one cycle after that.
- No internal buffering. Throughput is up to WPORTS_NUM writes per cycle, reduced by address conflicts.

## Test plan
- Sweep (DATA_DEPTH=8, WPORTS_NUM=2): release rst → INIT writes addr {0,1},{2,3},{4,5},{6,7} with data 0 and we all ones at cycles 1-4. init_busy_o falls after the 4th step. Also DATA_DEPTH=7: the 4th step has port1 en_w=0.
- Distinct addresses (REQ_NUM=4, ports=2, ptr=0, requesters 0,1,2 valid at 0x10,0x11,0x12):
  - cycle t: ready=0b0011; t+1: port0=0x10, port1=0x11; ptr=2.
  - req2 held → cycle t+1: ready=0b0100; t+2: port0=0x12.
- Address conflict: requesters 0 and 1 both at 0x20 with data A and B → only req0 ready. Next cycle port0 writes A, port1 en_w=0. req1 is granted the following cycle and B is written.
- Fairness: all 4 requesters valid continuously, 2 ports → grants alternate 0b0011, 0b1100, 0b0011, … with no starvation.
- clear_i in RUN while requests are pending → ready=0 that cycle, init_busy_o=1 next cycle, full zero sweep, then arbitration resumes with ptr unchanged.
- rst asserted mid-INIT (cnt=4) → all outputs 0 next cycle, and the sweep restarts from address 0 after release.
